jiaquan_mac_core: RTL
=====================

Name: jiaquan_mac_core

Overview:
- Weighted-sum engine behind the jiaquan AXI4-Lite register slave. It sits downstream of the slave's register file.
- The slave drives packed samples and weights from its registers and pulses start. This core performs a sequential signed multiply-accumulate across LANES lanes.
- It optionally rounds and shifts the sum, optionally accumulates onto the prior result with saturation, and returns the result and status for register readback.

Parameters:
- LANES, 4, number of sample/weight lanes processed per operation (>=2).
- DW, 8, signed width of each sample and each weight.
- RW, 32, signed result width (RW >= 2*DW+clog2(LANES)).
- SHIFT, 0, arithmetic right shift applied to each operation's sum, with round-half-up.

Ports:
- S_AXI_ACLK, in, 1, clock; all logic is on the rising edge.
- S_AXI_ARESETN, in, 1, synchronous active-low reset.
- start, in, 1, single-cycle request; sampled only in IDLE.
- acc_en, in, 1, sampled with start; 1 = add the new sum to the current result, 0 = overwrite it.
- clr, in, 1, clears result and sat.
- samples, in, LANES*DW, lane i at [i*DW +: DW], two's complement.
- weights, in, LANES*DW, same packing as samples.
- busy, out, 1, high from the cycle after start is accepted until done.
- done, out, 1, one-cycle pulse when result is updated.
- result, out, RW, signed result register.
- sat, out, 1, sticky flag: an update saturated.

Behaviour:
- Synchronous reset (S_AXI_ARESETN=0 at an edge):
  - state=IDLE; busy, done, sat, result, lane index and partial sum all 0.
  - Applies in any state; an in-flight operation is abandoned with no done.
- States: IDLE, MAC, FIN.
- IDLE:
  - start=1 at edge k latches samples, weights and acc_en.
  - Clears partial and lane index; goes to MAC; busy=1 from edge k.
- MAC:
  - At each edge, partial += sext(s[idx]) * sext(w[idx]); idx increments.
  - Lane 0 first. After LANES edges (edge k+LANES), go to FIN.
  - partial width PW = 2*DW+clog2(LANES), signed; it cannot overflow.
- FIN, at edge k+LANES+1:
  - v = (partial + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, in PW+1 bits.
  - New value = acc_en ? result + sext(v) : sext(v), computed at RW+1 bits.
  - Clamp to [-2^(RW-1), 2^(RW-1)-1]. On clamping, sat<=1.
  - result updated, done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency: done is high in the cycle following edge k+LANES+1, i.e. LANES+1 cycles after the start edge. Back-to-back: start is honoured in the same cycle done is high (the state is IDLE then).
- start while busy: ignored, not queued.
- Input changes during MAC/FIN: no effect; operands are latched.
- clr:
  - Any state: result<=0, sat<=0 at that edge.
  - If coincident with the FIN edge, the FIN write uses 0 as the accumulation base and sat reflects only this update. clr does not abort an operation.
- clr and start in the same IDLE cycle: both take effect; the operation begins with result=0.
- Wrap-around: none. Accumulation saturates and holds at the limit. Further saturating updates keep sat=1.

Decomposition:
- Package jiaquan_pkg holds:
  - state encoding IDLE/MAC/FIN;
  - the clog2 function;
  - localparam PW derivation;
  - the lane-extract helper.
- One sub-module: jiaquan_sat_add (signed (RW+1)-bit add, clamp to RW, overflow flag out), combinational. Used in FIN.

Test Plan:
1. Default params; samples lanes {1,2,3,4}, weights {5,6,7,8}, acc_en=0, start -> result=0x00000046, done exactly 5 cycles after the start edge, busy high 5 cycles, sat=0.
2. All samples 0x80, all weights 0x80 -> result=0x00010000. Then samples 0x80, weights 0x7F, acc_en=0 -> result=0xFFFF0200.
3. RW=20; repeated all-0x80 ops with acc_en=1:
   - 7th done -> result=0x70000;
   - 8th -> clamp 0x7FFFF, sat=1;
   - 9th -> stays 0x7FFFF, sat=1;
   - then clr -> result=0, sat=0.
4. SHIFT=2; scenario-1 operands -> result=18 (70/4 rounded half-up). Sum -6 (samples {-1,-1,-1,-3}, weights {1,1,1,1}) -> result=-1 (0xFFFFFFFF).
5. Start accepted, then second start with different operands 2 cycles later -> ignored; single done; result=0x46.
6. Assert S_AXI_ARESETN=0 during the MAC lane-2 cycle -> next cycle busy=0, result=0, and no done follows. A fresh start after reset yields the correct value.

Source files
------------

// File: rtl/jiaquan_pkg.sv
// Shared definitions for the jiaquan weighted-sum engine: FSM encoding,
// width helpers and the lane extraction used on the packed operand buses.
package jiaquan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Widest packed operand bus the lane helper can serve (LANES*DW).
   localparam int MAX_BUS = 512;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Partial-sum width: full product plus growth for LANES additions.
   function automatic int pw_calc(input int lanes, input int dw);
      return 2 * dw + clog2(lanes);
   endfunction

   // Brings lane `lane` of a packed bus down to bit 0; caller keeps the low width bits.
   function automatic logic [MAX_BUS-1:0] lane_shift(input logic [MAX_BUS-1:0] bus,
                                                     input int lane,
                                                     input int width);
      return bus >> (lane * width);
   endfunction

endpackage

// File: rtl/jiaquan_sat_add.sv
// Signed add of two RW-bit values at RW+1 bits, clamped back to RW bits.
module jiaquan_sat_add #(
   parameter int RW = 32
) (
   input  logic signed [RW-1:0] a,
   input  logic signed [RW-1:0] b,
   output logic signed [RW-1:0] sum,
   output logic                 ovf
);

   localparam logic signed [RW-1:0] MAX_R = {1'b0, {(RW-1){1'b1}}};
   localparam logic signed [RW-1:0] MIN_R = {1'b1, {(RW-1){1'b0}}};
   localparam logic signed [RW:0]   MAX_W = {2'b00, {(RW-1){1'b1}}};
   localparam logic signed [RW:0]   MIN_W = {2'b11, {(RW-1){1'b0}}};

   logic signed [RW:0] full;

   always_comb begin
      full = (RW+1)'(a) + (RW+1)'(b);
      sum  = full[RW-1:0];
      ovf  = 1'b0;
      if (full > MAX_W) begin
         sum = MAX_R;
         ovf = 1'b1;
      end else if (full < MIN_W) begin
         sum = MIN_R;
         ovf = 1'b1;
      end
   end

endmodule

// File: rtl/jiaquan_mac_core.sv
// Sequential signed multiply-accumulate over LANES lanes with optional
// round/shift and saturating accumulation onto the previous result.
module jiaquan_mac_core
   import jiaquan_pkg::*;
#(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int RW    = 32,
   parameter int SHIFT = 0
) (
   input  logic                    S_AXI_ACLK,
   input  logic                    S_AXI_ARESETN,
   input  logic                    start,
   input  logic                    acc_en,
   input  logic                    clr,
   input  logic [LANES*DW-1:0]     samples,
   input  logic [LANES*DW-1:0]     weights,
   output logic                    busy,
   output logic                    done,
   output logic signed [RW-1:0]    result,
   output logic                    sat
);

   localparam int PW  = pw_calc(LANES, DW);
   localparam int IW  = (clog2(LANES) < 1) ? 1 : clog2(LANES);
   localparam int BUS = LANES * DW;
   localparam logic signed [PW:0] RND =
      (SHIFT > 0) ? (PW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0) : '0;

   state_t state_q, state_d;

   logic [IW-1:0]          idx_q;
   logic [BUS-1:0]         samples_p0, weights_p0;
   logic                   acc_p0;
   logic signed [PW-1:0]   partial_p1;
   logic signed [DW-1:0]   s_lane, w_lane;
   logic signed [2*DW-1:0] prod;
   logic signed [RW-1:0]   v_rw, base_rw, sum_rw;
   logic                   ovf;

   // Round-half-up then arithmetic shift; the extra bit absorbs the rounding add.
   function automatic logic signed [PW:0] round_shift(input logic signed [PW-1:0] p);
      logic signed [PW:0] t;
      t = (PW+1)'(p) + RND;
      return t >>> SHIFT;
   endfunction

   assign s_lane  = DW'(lane_shift(MAX_BUS'(samples_p0), 32'(idx_q), DW));
   assign w_lane  = DW'(lane_shift(MAX_BUS'(weights_p0), 32'(idx_q), DW));
   assign prod    = s_lane * w_lane;
   assign v_rw    = RW'(round_shift(partial_p1));
   // A clr landing on the FIN edge makes this update start from zero.
   assign base_rw = (acc_p0 && !clr) ? result : '0;

   jiaquan_sat_add #(.RW(RW)) u_sat_add (
      .a   (base_rw),
      .b   (v_rw),
      .sum (sum_rw),
      .ovf (ovf)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = MAC;
         MAC:     if (idx_q == IW'(LANES - 1)) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_q    <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         sat        <= 1'b0;
         result     <= '0;
         idx_q      <= '0;
         partial_p1 <= '0;
         samples_p0 <= '0;
         weights_p0 <= '0;
         acc_p0     <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != IDLE);
         done    <= (state_q == FIN);

         // p0: operand capture in IDLE
         if (state_q == IDLE && start) begin
            samples_p0 <= samples;
            weights_p0 <= weights;
            acc_p0     <= acc_en;
            idx_q      <= '0;
            partial_p1 <= '0;
         end

         // p1: one lane product accumulated per MAC cycle
         if (state_q == MAC) begin
            partial_p1 <= partial_p1 + PW'(prod);
            idx_q      <= idx_q + IW'(1);
         end

         // p2: round, accumulate and clamp into the result register
         if (state_q == FIN) begin
            result <= sum_rw;
            sat    <= ovf | (sat & ~clr);
         end else if (clr) begin
            result <= '0;
            sat    <= 1'b0;
         end
      end
   end

endmodule
